// File: rtl/hc08_tester.sv
// Sequential stimulus generator / response checker for 74HC08-style AND gates.
// Optional crosstalk vectors enabled by defining HC08_TESTER_XTALK_EN.
module hc08_tester #(
    parameter int unsigned GATES  = 4,
    parameter int unsigned SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [GATES-1:0] sense_y,
    output logic [GATES-1:0] drv_a,
    output logic [GATES-1:0] drv_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [GATES-1:0] fail_mask,
    output logic [7:0]       err_count
);

`ifdef HC08_TESTER_XTALK_EN
    localparam int unsigned NV    = 4 + GATES;
    localparam int unsigned IDX_W = $clog2(NV);
`else
    localparam int unsigned NV    = 4;
    localparam int unsigned IDX_W = 2;
`endif
    localparam logic [8:0]       WAIT_LAST = 9'(SETTLE + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [8:0]         wait_q, wait_d;
    logic [GATES-1:0]   drv_a_q, drv_a_d;
    logic [GATES-1:0]   drv_b_q, drv_b_d;
    logic               pass_q, pass_d;
    logic [GATES-1:0]   fail_q, fail_d;
    logic [7:0]         err_q, err_d;
    logic [GATES-1:0]   sync1_q, sy_q;

    logic [2*GATES-1:0] cur_vec, nxt_vec;
    logic [GATES-1:0]   mism;
    logic [3:0]         ecnt;
    logic [8:0]         esum;
    logic [7:0]         esat;

    // Packs {drv_a, drv_b} for vector v; expected output is the AND of the halves.
    function automatic logic [2*GATES-1:0] vec_ab(input logic [IDX_W-1:0] v);
`ifdef HC08_TESTER_XTALK_EN
        if (int'(v) >= 4) return {2{GATES'(1) << (int'(v) - 4)}};
`endif
        return {{GATES{v[1]}}, {GATES{v[0]}}};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            drv_a_q <= '0;
            drv_b_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            err_q   <= '0;
            sync1_q <= '0;
            sy_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            drv_a_q <= drv_a_d;
            drv_b_q <= drv_b_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            sync1_q <= sense_y;
            sy_q    <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        drv_a_d = drv_a_q;
        drv_b_d = drv_b_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;

        cur_vec = vec_ab(idx_q);
        nxt_vec = vec_ab(idx_q + IDX_W'(1));
        mism    = sy_q ^ (cur_vec[2*GATES-1:GATES] & cur_vec[GATES-1:0]);
        ecnt    = '0;
        for (int unsigned i = 0; i < GATES; i++) begin
            ecnt = ecnt + 4'(mism[i]);
        end
        esum = {1'b0, err_q} + 9'(ecnt);
        esat = esum[8] ? 8'hFF : esum[7:0];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    fail_d  = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    drv_a_d = '0;
                    drv_b_d = '0;
                end
            end
            S_DRIVE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) state_d = S_SAMPLE;
                else                     wait_d  = wait_q + 9'd1;
            end
            S_SAMPLE: begin
                fail_d = fail_q | mism;
                err_d  = esat;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    drv_a_d = '0;
                    drv_b_d = '0;
                    pass_d  = (esat == 8'd0);
                end else begin
                    state_d = S_DRIVE;
                    idx_d   = idx_q + IDX_W'(1);
                    drv_a_d = nxt_vec[2*GATES-1:GATES];
                    drv_b_d = nxt_vec[GATES-1:0];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
        done = (state_q == S_DONE);
    end

    assign drv_a     = drv_a_q;
    assign drv_b     = drv_b_q;
    assign pass      = pass_q;
    assign fail_mask = fail_q;
    assign err_count = err_q;

endmodule
